// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: 16-bit LE word count, then LE words.
// Emits one write strobe per assembled word at offsets from the IMEM base.
module imem_loader #(
   parameter int MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        wr_en_o,
   output logic [31:0] wr_addr_o,
   output logic [31:0] wr_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [10:0] words_loaded_o
);

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
   } state_t;

   state_t      state, state_n;
   logic [7:0]  len_lo;
   logic [15:0] len;
   logic [1:0]  byte_cnt;
   logic [31:0] word_buf;
   logic [10:0] count;
   logic [10:0] count_inc;
   logic [15:0] len_in;
   logic        len_bad;
   logic        last;
   logic        xfer;

   assign byte_ready_o = (state == LEN_LO) || (state == LEN_HI)
                      || (state == DATA);
   assign busy_o  = byte_ready_o || (state == WRITE);
   assign wr_en_o = (state == WRITE);
   assign done_o  = (state == DONE);
   assign error_o = (state == ERR);

   assign xfer      = byte_valid_i && byte_ready_o;
   assign len_in    = {byte_data_i, len_lo};
   assign len_bad   = (len_in == 16'd0)
                   || ({16'd0, len_in} > 32'(MAX_WORDS));
   assign count_inc = count + 11'd1;
   assign last      = ({5'd0, count_inc} == len);

   // count never reaches MAX_WORDS while in WRITE, so 10 bits suffice
   assign wr_addr_o      = {20'd0, count[9:0], 2'b00};
   assign wr_data_o      = word_buf;
   assign words_loaded_o = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE, ERR: if (start_i) state_n = LEN_LO;
         LEN_LO:          if (xfer) state_n = LEN_HI;
         LEN_HI:          if (xfer) state_n = len_bad ? ERR : DATA;
         DATA:            if (xfer && byte_cnt == 2'd3) state_n = WRITE;
         WRITE:           state_n = last ? DONE : DATA;
         default:         state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_lo   <= '0;
         len      <= '0;
         byte_cnt <= '0;
         word_buf <= '0;
         count    <= '0;
      end else begin
         unique case (state)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  count    <= '0;
                  byte_cnt <= '0;
               end
            end
            LEN_LO: if (xfer) len_lo <= byte_data_i;
            LEN_HI: if (xfer) len <= len_in;
            DATA: begin
               if (xfer) begin
                  word_buf[8*byte_cnt +: 8] <= byte_data_i;
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            WRITE:   count <= count_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a stream-level model.
// Writes are captured by a monitor and compared to words derived from bytes.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        wr_en_o;
   logic [31:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic [10:0] words_loaded_o;

   int checks = 0;
   int errors = 0;
   int start_at = -1;
   logic [7:0]  stream[$];
   logic [63:0] wq[$];

   imem_loader #(.MAX_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
      .byte_ready_o(byte_ready_o), .wr_en_o(wr_en_o),
      .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .words_loaded_o(words_loaded_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && wr_en_o) wq.push_back({wr_addr_o, wr_data_o});

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("start_busy", busy_o, 1);
      chk("start_done", done_o, 0);
      chk("start_err", error_o, 0);
      chk("start_words", words_loaded_o, 0);
   endtask

   task automatic build(input int nfield, input int nwords, input int kind);
      stream.delete();
      stream.push_back(nfield[7:0]);
      stream.push_back(nfield[15:8]);
      for (int i = 0; i < 4 * nwords; i++) begin
         logic [31:0] r;
         r = (kind == 1) ? i : $urandom;
         stream.push_back(r[7:0]);
      end
   endtask

   // gap_mode: 0 none, 1 three idle cycles, 2 random 0..3
   task automatic send(input int gap_mode, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         int budget;
         int g;
         byte_valid_i = 1'b1;
         byte_data_i  = stream[i];
         if (i == start_at) start_i = 1'b1;
         budget = 0;
         while (!byte_ready_o && budget < 100) begin
            @(negedge clk);
            start_i = 1'b0;
            budget++;
         end
         if (budget >= 100) begin
            chk("ready_timeout", 0, 1);
            byte_valid_i = 1'b0;
            return;
         end
         @(negedge clk);
         start_i = 1'b0;
         g = (gap_mode == 1) ? 3 : (gap_mode == 2) ? $urandom_range(0, 3) : 0;
         for (int k = 0; k < g; k++) begin
            logic [31:0] r;
            r = $urandom;
            byte_valid_i = 1'b0;
            byte_data_i  = r[7:0];
            @(negedge clk);
         end
      end
      byte_valid_i = 1'b0;
   endtask

   task automatic finish_wait();
      int budget = 0;
      while (busy_o && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (busy_o) chk("idle_timeout", busy_o, 0);
   endtask

   task automatic check_session(input string tag);
      int n;
      int nexp;
      bit bad;
      n    = {stream[1], stream[0]};
      bad  = (n == 0) || (n > 1024);
      nexp = bad ? 0 : n;
      chk({tag, "_nwr"}, wq.size(), nexp);
      for (int i = 0; i < nexp && i < wq.size(); i++) begin
         logic [31:0] w;
         w = stream[2 + 4 * i]
           + (stream[3 + 4 * i] << 8)
           + (stream[4 + 4 * i] << 16)
           + (stream[5 + 4 * i] << 24);
         chk({tag, "_addr"}, wq[i][63:32], 4 * i);
         chk({tag, "_data"}, wq[i][31:0], w);
      end
      chk({tag, "_done"}, done_o, !bad);
      chk({tag, "_err"}, error_o, bad);
      chk({tag, "_words"}, words_loaded_o, nexp);
      chk({tag, "_busy"}, busy_o, 0);
   endtask

   task automatic session(input string tag, input int gap_mode);
      wq.delete();
      do_start();
      send(gap_mode, stream.size());
      finish_wait();
      check_session(tag);
   endtask

   task automatic load_demo();
      stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h93, 8'h05, 8'hB0, 8'h00};
   endtask

   initial begin
      rst = 1'b1;
      start_i = 1'b0;
      byte_valid_i = 1'b0;
      byte_data_i = 8'h00;
      #1;
      chk("rst_ready", byte_ready_o, 0);
      chk("rst_wren", wr_en_o, 0);
      chk("rst_addr", wr_addr_o, 0);
      chk("rst_data", wr_data_o, 0);
      chk("rst_flags", {busy_o, done_o, error_o}, 0);
      chk("rst_words", words_loaded_o, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", byte_ready_o, 0);

      load_demo();
      session("demo", 0);
      chk("demo_w0", wq.size() > 0 ? wq[0] : 64'd0,
          64'h0000_0000_00A0_0513);

      build(0, 0, 0);
      session("zero", 0);

      build(1025, 0, 0);
      session("big", 0);
      do_start();
      send(0, 2);
      finish_wait();

      load_demo();
      session("gaps", 1);

      load_demo();
      wq.delete();
      do_start();
      send(0, 4);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_flags", {busy_o, done_o, error_o, byte_ready_o}, 0);
      chk("mid_rst_wr", {wr_en_o, wr_addr_o, wr_data_o}, 0);
      chk("mid_rst_words", words_loaded_o, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_nwr", wq.size(), 0);
      chk("mid_rst_idle", busy_o, 0);
      session("after_rst", 0);

      build(1024, 1024, 1);
      start_at = 2000;
      session("full", 0);
      start_at = -1;
      chk("full_last", wq.size() == 1024 ? wq[1023][63:32] : 0, 32'hFFC);

      for (int s = 0; s < 4; s++) begin
         int n;
         n = $urandom_range(1, 24);
         build(n, n, 0);
         session("rand", 2);
      end
      build(1025 + $urandom_range(0, 3000), 0, 0);
      session("rand_bad", 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024: instruction memory capacity in 32-bit words (4 KiB).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  request to begin a load session.
REQ-005 byte_valid_i  input  1  byte_data_i holds a valid stream byte.
REQ-006 byte_data_i  input  8  stream byte.
REQ-007 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-008 wr_en_o  output  1  one-cycle write strobe to instruction memory.
REQ-009 wr_addr_o  output  32  word-aligned byte offset from instruction memory base 0xBFC00000.
REQ-010 wr_data_o  output  32  instruction word to write.
REQ-011 busy_o  output  1  session in progress.
REQ-012 done_o  output  1  session completed successfully; sticky.
REQ-013 error_o  output  1  session aborted on bad length; sticky.
REQ-014 words_loaded_o  output  11  count of words written in the current or last session.

Function
REQ-015 A byte transfer SHALL occur only on a rising edge where byte_valid_i and byte_ready_o are both 1; byte_data_i SHALL be ignored otherwise.
REQ-016 Stream format SHALL be: length LSB, length MSB (word count N, 16-bit little-endian), then 4*N data bytes.
REQ-017 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-018 IDLE/DONE/ERR: byte_ready_o=0, busy_o=0; start_i=1 -> LEN_LO, clearing words_loaded_o, done_o, error_o and word index.
REQ-019 start_i SHALL be ignored while busy_o=1.
REQ-020 LEN_LO: byte_ready_o=1; on transfer, store length[7:0] -> LEN_HI.
REQ-021 LEN_HI: byte_ready_o=1; on transfer, store length[15:8]; if N==0 or N>MAX_WORDS -> ERR, else -> DATA.
REQ-022 DATA: byte_ready_o=1; k-th accepted byte of a word (k=0..3) SHALL be placed in bits [8k+7:8k] (little-endian); after the 4th byte -> WRITE.
REQ-023 WRITE: byte_ready_o=0; wr_en_o=1 for exactly one cycle with wr_addr_o=4*word index and wr_data_o=assembled word; then increment word index and words_loaded_o.
REQ-024 From WRITE: if the incremented count equals N -> DONE, else -> DATA.
REQ-025 wr_en_o SHALL be 0 in every state other than WRITE; wr_addr_o never exceeds 4*(MAX_WORDS-1) and bits [1:0] are always 0.
REQ-026 busy_o SHALL be 1 exactly in LEN_LO, LEN_HI, DATA, WRITE.
REQ-027 DONE: done_o=1; ERR: error_o=1; both held until the next accepted start_i; never both 1.
REQ-028 Minimum latency SHALL be 5 cycles per word (4 byte transfers + 1 WRITE); byte_valid_i gaps only stall, never corrupt assembly.

Reset
REQ-029 Assertion of rst SHALL immediately force state IDLE and all outputs to 0 (wr_addr_o, wr_data_o, words_loaded_o = 0), independent of clk.
REQ-030 Reset mid-session SHALL discard any partial word, issue no wr_en_o, and require a fresh start_i.

Verification
REQ-031 start_i, bytes 02 00 13 05 A0 00 93 05 B0 00 -> wr_en_o pulses: addr 0x0 data 0x00A00513, addr 0x4 data 0x00B00593; then done_o=1, words_loaded_o=2, busy_o=0.
REQ-032 start_i, bytes 00 00 -> error_o=1, done_o=0, no wr_en_o pulse.
REQ-033 start_i, bytes 01 04 (N=1025) -> error_o=1 after LEN_HI, no writes; a new start_i clears error_o.
REQ-034 Same stream as REQ-031 with byte_valid_i low 3 cycles between every byte and held high during WRITE -> identical writes; no byte consumed while byte_ready_o=0.
REQ-035 rst asserted after 2 data bytes of word 0 -> all outputs 0 asynchronously; subsequent start_i with REQ-031 stream produces REQ-031 results.
REQ-036 N=1024 (00 04) with incrementing data -> 1024 writes, last at addr 0xFFC, words_loaded_o=1024, done_o=1; start_i pulsed mid-session has no effect.
